// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared I2S control word, mode encodings and tx serializer state/constants.
package ctrl_pkg;
   typedef enum logic [1:0] {MR, MT, SR, ST} mode_t;
   typedef enum logic {f16bits, f32bits} frame_t;
   typedef enum logic {I2S, MSB} std_t;
   typedef struct packed {
      mode_t  mode;
      logic   tran_en;
      logic   stereo;
      frame_t frame_size;
      std_t   standard;
   } OP_t;
   typedef enum logic [1:0] {TS_IDLE, TS_SHIFT, TS_PAD} tx_ser_state_t;
   localparam int W32 = 32;
   localparam int W16 = 16;
   function automatic logic [4:0] last_bit(input frame_t f);
      return f == f32bits ? 5'(W32 - 1) : 5'(W16 - 1);
   endfunction
endpackage

// File: rtl/slot_detect.sv
// slot_detect: flags a channel-slot start from a ws edge or, in mono, from slot length rollover.
module slot_detect
   import ctrl_pkg::*;
(
   input  logic   sclk,
   input  logic   preset,
   input  logic   active,
   input  logic   stereo,
   input  frame_t frame_size,
   input  logic   ws,
   input  logic   tx_ren,
   output logic   start
);
   logic       ws_q;
   logic [4:0] slot_cnt;
   assign start = active && ((ws != ws_q && tx_ren) ||
                  (!stereo && ws == ws_q && slot_cnt == last_bit(frame_size)));
   always_ff @(negedge sclk or posedge preset)
      if (preset) begin
         ws_q     <= 1'b0;
         slot_cnt <= '0;
      end else begin
         ws_q     <= ws;
         slot_cnt <= (!active || start) ? '0 : slot_cnt + 5'd1;
      end
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: pops one Tx FIFO sample per slot and shifts it out MSB-first,
// with the one-bit Philips delay or none for MSB-justified.
module i2s_tx_serializer
   import ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          sclk,
   input  logic          preset,
   input  OP_t           OP,
   input  logic          ws,
   input  logic          tx_ren,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_empty,
   output logic          tx_pop,
   output logic          sd,
   output logic          busy,
   output logic          underrun
);
   tx_ser_state_t state, state_nxt;
   logic [DW-1:0] shreg, word;
   logic [4:0]    bit_cnt;
   logic          active, start, sd_d;
   assign active = OP.tran_en && (OP.mode == MT || OP.mode == ST);
   assign word   = OP.frame_size == f32bits ? tx_data << (DW - W32) : tx_data << (DW - W16);
   slot_detect u_slot (
      .sclk       (sclk),
      .preset     (preset),
      .active     (active),
      .stereo     (OP.stereo),
      .frame_size (OP.frame_size),
      .ws         (ws),
      .tx_ren     (tx_ren),
      .start      (start)
   );
   always_ff @(negedge sclk or posedge preset)
      if (preset) state <= TS_IDLE;
      else        state <= state_nxt;
   // a reload beats end-of-word; a disabled transmitter finishes its word then idles
   always_comb
      state_nxt = start                               ? TS_SHIFT :
                  state == TS_SHIFT && bit_cnt == '0  ? (active ? TS_PAD : TS_IDLE) :
                  state == TS_PAD && !active          ? TS_IDLE : state;
   always_comb begin
      tx_pop = start && !tx_empty;
      busy   = state != TS_IDLE;
      sd     = OP.standard == I2S ? sd_d : shreg[DW-1];
   end
   always_ff @(negedge sclk or posedge preset)
      if (preset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         underrun <= 1'b0;
         sd_d     <= 1'b0;
      end else begin
         sd_d     <= shreg[DW-1];
         underrun <= OP.tran_en && (underrun || (start && tx_empty));
         if (start) begin
            shreg   <= tx_empty ? '0 : word;
            bit_cnt <= last_bit(OP.frame_size);
         end else if (state == TS_SHIFT) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 5'd1;
         end
      end
endmodule
